// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through L1 request/return protocol, serving icache and
// dcache requests one at a time from an on-chip SRAM of 64-bit words.
module wt_mem_responder #(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned MemWords  = 4096,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 icache_data_req_i,
  output logic                 icache_data_ack_o,
  input  logic [63:0]          icache_paddr_i,
  input  logic                 icache_nc_i,
  input  logic [TidWidth-1:0]  icache_tid_i,
  output logic                 icache_rtrn_vld_o,
  output logic [LineWidth-1:0] icache_rtrn_data_o,
  output logic [TidWidth-1:0]  icache_rtrn_tid_o,
  input  logic                 dcache_data_req_i,
  output logic                 dcache_data_ack_o,
  input  logic                 dcache_rtype_i,
  input  logic [63:0]          dcache_paddr_i,
  input  logic [2:0]           dcache_size_i,
  input  logic [63:0]          dcache_data_i,
  input  logic [TidWidth-1:0]  dcache_tid_i,
  output logic                 dcache_rtrn_vld_o,
  output logic                 dcache_rtrn_type_o,
  output logic [LineWidth-1:0] dcache_rtrn_data_o,
  output logic [TidWidth-1:0]  dcache_rtrn_tid_o
);

  localparam int unsigned Beats = LineWidth / 64;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned WordW = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned AddrW = WordW + 3;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e               state_q, state_d;
  logic                 prio_q;   // 0: icache wins a conflict, 1: dcache wins
  logic                 port_q;   // 1: transaction owned by dcache
  logic                 store_q;
  logic                 single_q;
  logic [AddrW-1:0]     addr_q;
  logic [2:0]           size_q;
  logic [63:0]          wdata_q;
  logic [TidWidth-1:0]  tid_q;
  logic [CntW-1:0]      beat_q, beat_d;
  logic [LineWidth-1:0] line_q, line_d;
  logic [63:0]          mem_q [MemWords];

  logic                 ic_vld_q, dc_vld_q, dc_type_q;
  logic [LineWidth-1:0] ic_data_q, dc_data_q;
  logic [TidWidth-1:0]  ic_tid_q, dc_tid_q;

  logic                 grant_ic, grant_dc, last_beat, go_resp;
  logic [WordW-1:0]     word_idx, rd_idx;
  logic [CntW-1:0]      lane;
  logic [63:0]          rd_word;
  logic [1:0]           size_eff;
  logic [3:0]           be_lo, be_hi;
  logic [7:0]           be;
  logic                 unused_paddr;

  // Only the word-index and byte-offset bits of the address matter; upper bits wrap away.
  assign unused_paddr = ^{icache_paddr_i[63:AddrW], dcache_paddr_i[63:AddrW]};

  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state_q == StIdle) begin
      if (icache_data_req_i && dcache_data_req_i) begin
        grant_ic = ~prio_q;
        grant_dc = prio_q;
      end else begin
        grant_ic = icache_data_req_i;
        grant_dc = dcache_data_req_i;
      end
    end
  end

  assign icache_data_ack_o = grant_ic;
  assign dcache_data_ack_o = grant_dc;

  assign word_idx  = addr_q[AddrW-1:3];
  assign last_beat = single_q || (beat_q == CntW'(Beats - 1));
  assign lane      = single_q ? ((Beats > 1) ? addr_q[3 +: CntW] : '0) : beat_q;
  // Line base is aligned to Beats words, so OR-ing the beat number is the same as adding it.
  assign rd_idx    = single_q ? word_idx : ((word_idx & ~WordW'(Beats - 1)) | WordW'(beat_q));
  assign rd_word   = mem_q[rd_idx];

  always_comb begin
    line_d = line_q;
    if (state_q == StRead) line_d[{lane, 6'b0} +: 64] = rd_word;
  end

  always_comb begin
    size_eff = (size_q > 3'd3) ? 2'd3 : size_q[1:0];
    be_lo    = {1'b0, addr_q[2:0]};
    be_hi    = be_lo + (4'd1 << size_eff);
    for (int i = 0; i < 8; i++) be[i] = (4'(i) >= be_lo) && (4'(i) < be_hi);
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    go_resp = 1'b0;
    case (state_q)
      StIdle: begin
        beat_d = '0;
        if (grant_ic)      state_d = StRead;
        else if (grant_dc) state_d = dcache_rtype_i ? StWrite : StRead;
      end
      StRead: begin
        if (last_beat) begin
          state_d = StResp;
          go_resp = 1'b1;
        end else begin
          beat_d = beat_q + CntW'(1);
        end
      end
      StWrite: begin
        state_d = StResp;
        go_resp = 1'b1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      prio_q    <= 1'b0;
      port_q    <= 1'b0;
      store_q   <= 1'b0;
      single_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      tid_q     <= '0;
      beat_q    <= '0;
      line_q    <= '0;
      ic_vld_q  <= 1'b0;
      ic_data_q <= '0;
      ic_tid_q  <= '0;
      dc_vld_q  <= 1'b0;
      dc_type_q <= 1'b0;
      dc_data_q <= '0;
      dc_tid_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      if (grant_ic || grant_dc) begin
        prio_q   <= grant_ic;
        port_q   <= grant_dc;
        store_q  <= grant_dc & dcache_rtype_i;
        single_q <= grant_dc ? (dcache_size_i != 3'd7) : icache_nc_i;
        addr_q   <= grant_dc ? dcache_paddr_i[AddrW-1:0] : icache_paddr_i[AddrW-1:0];
        size_q   <= grant_dc ? dcache_size_i : 3'd7;
        wdata_q  <= dcache_data_i;
        tid_q    <= grant_dc ? dcache_tid_i : icache_tid_i;
        line_q   <= '0;
      end
      // Return registers are loaded for exactly the RESP cycle and zero otherwise.
      ic_vld_q  <= go_resp & ~port_q;
      ic_data_q <= (go_resp && !port_q) ? line_d : '0;
      ic_tid_q  <= (go_resp && !port_q) ? tid_q : '0;
      dc_vld_q  <= go_resp & port_q;
      dc_type_q <= go_resp & port_q & store_q;
      dc_data_q <= (go_resp && port_q && !store_q) ? line_d : '0;
      dc_tid_q  <= (go_resp && port_q) ? tid_q : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == StWrite) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign icache_rtrn_vld_o  = ic_vld_q;
  assign icache_rtrn_data_o = ic_data_q;
  assign icache_rtrn_tid_o  = ic_tid_q;
  assign dcache_rtrn_vld_o  = dc_vld_q;
  assign dcache_rtrn_type_o = dc_type_q;
  assign dcache_rtrn_data_o = dc_data_q;
  assign dcache_rtrn_tid_o  = dc_tid_q;

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed bench for wt_mem_responder: stores, line/word loads, wrap, arbitration and reset abort.
module tb_wt_mem_responder;

  logic         clk_i;
  logic         rst_ni;
  logic         icache_data_req_i;
  logic         icache_data_ack_o;
  logic [63:0]  icache_paddr_i;
  logic         icache_nc_i;
  logic [1:0]   icache_tid_i;
  logic         icache_rtrn_vld_o;
  logic [127:0] icache_rtrn_data_o;
  logic [1:0]   icache_rtrn_tid_o;
  logic         dcache_data_req_i;
  logic         dcache_data_ack_o;
  logic         dcache_rtype_i;
  logic [63:0]  dcache_paddr_i;
  logic [2:0]   dcache_size_i;
  logic [63:0]  dcache_data_i;
  logic [1:0]   dcache_tid_i;
  logic         dcache_rtrn_vld_o;
  logic         dcache_rtrn_type_o;
  logic [127:0] dcache_rtrn_data_o;
  logic [1:0]   dcache_rtrn_tid_o;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] WordA = 64'h1122334455667788;
  localparam logic [63:0] WordB = 64'hAABBCCDDEEFF0011;
  localparam logic [63:0] WordP = 64'h11223344EE667788;
  localparam logic [63:0] WordH = 64'h12343344EE667788;
  localparam logic [63:0] WordW = 64'hDEADBEEFCAFEF00D;

  int exp_cyc[4]  = '{0, 4, 7, 11};
  bit exp_port[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  wt_mem_responder #(
    .LineWidth(128),
    .MemWords (4096),
    .TidWidth (2)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .icache_data_req_i (icache_data_req_i),
    .icache_data_ack_o (icache_data_ack_o),
    .icache_paddr_i    (icache_paddr_i),
    .icache_nc_i       (icache_nc_i),
    .icache_tid_i      (icache_tid_i),
    .icache_rtrn_vld_o (icache_rtrn_vld_o),
    .icache_rtrn_data_o(icache_rtrn_data_o),
    .icache_rtrn_tid_o (icache_rtrn_tid_o),
    .dcache_data_req_i (dcache_data_req_i),
    .dcache_data_ack_o (dcache_data_ack_o),
    .dcache_rtype_i    (dcache_rtype_i),
    .dcache_paddr_i    (dcache_paddr_i),
    .dcache_size_i     (dcache_size_i),
    .dcache_data_i     (dcache_data_i),
    .dcache_tid_i      (dcache_tid_i),
    .dcache_rtrn_vld_o (dcache_rtrn_vld_o),
    .dcache_rtrn_type_o(dcache_rtrn_type_o),
    .dcache_rtrn_data_o(dcache_rtrn_data_o),
    .dcache_rtrn_tid_o (dcache_rtrn_tid_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // One transaction on a single port; optionally raises the other port's request in the same
  // cycle (with whatever fields it already holds) to exercise arbitration.
  task automatic txn(input string name, input bit dport, input bit rtype, input bit nc,
                     input logic [63:0] addr, input logic [2:0] size, input logic [63:0] wdata,
                     input logic [1:0] tid, input int exp_lat, input logic [127:0] exp_data,
                     input bit both);
    int lat;
    bit seen;
    @(negedge clk_i);
    if (dport) begin
      dcache_rtype_i = rtype;
      dcache_paddr_i = addr;
      dcache_size_i  = size;
      dcache_data_i  = wdata;
      dcache_tid_i   = tid;
    end else begin
      icache_nc_i    = nc;
      icache_paddr_i = addr;
      icache_tid_i   = tid;
    end
    icache_data_req_i = ~dport | both;
    dcache_data_req_i = dport | both;
    #1;
    check_eq({name, "_ack"}, dport ? dcache_data_ack_o : icache_data_ack_o, 1);
    check_eq({name, "_other_ack"}, dport ? icache_data_ack_o : dcache_data_ack_o, 0);
    @(posedge clk_i);
    #1;
    icache_data_req_i = 1'b0;
    dcache_data_req_i = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk_i);
      lat++;
      check_eq({name, "_other_vld"}, dport ? icache_rtrn_vld_o : dcache_rtrn_vld_o, 0);
      seen = dport ? dcache_rtrn_vld_o : icache_rtrn_vld_o;
    end
    check_eq({name, "_seen"}, seen, 1);
    check_eq({name, "_lat"}, lat, exp_lat);
    check_eq({name, "_data"}, dport ? dcache_rtrn_data_o : icache_rtrn_data_o, exp_data);
    check_eq({name, "_tid"}, dport ? dcache_rtrn_tid_o : icache_rtrn_tid_o, tid);
    if (dport) check_eq({name, "_type"}, dcache_rtrn_type_o, rtype);
  endtask

  initial begin
    int n_ack;
    int n_ic;
    int n_dc;
    rst_ni            = 1'b0;
    icache_data_req_i = 1'b0;
    icache_paddr_i    = '0;
    icache_nc_i       = 1'b0;
    icache_tid_i      = '0;
    dcache_data_req_i = 1'b0;
    dcache_rtype_i    = 1'b0;
    dcache_paddr_i    = '0;
    dcache_size_i     = '0;
    dcache_data_i     = '0;
    dcache_tid_i      = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_ic_vld", icache_rtrn_vld_o, 0);
    check_eq("rst_dc_vld", dcache_rtrn_vld_o, 0);
    check_eq("rst_dc_data", dcache_rtrn_data_o, 0);
    rst_ni = 1'b1;

    // name        port rt nc addr        sz    wdata                tid lat exp_data
    txn("st_a",    1, 1, 0, 64'h100,  3'd3, WordA,               2'd1, 2, 128'h0, 0);
    txn("st_b",    1, 1, 0, 64'h108,  3'd3, WordB,               2'd2, 2, 128'h0, 0);
    txn("ld_line", 1, 0, 0, 64'h104,  3'd7, 64'h0,               2'd3, 3, {WordB, WordA}, 0);
    txn("st_byte", 1, 1, 0, 64'h103,  3'd0, 64'hEE << 24,        2'd0, 2, 128'h0, 0);
    txn("ld_word", 1, 0, 0, 64'h100,  3'd3, 64'h0,               2'd1, 2, {64'h0, WordP}, 0);
    txn("ic_nc",   0, 0, 1, 64'h108,  3'd0, 64'h0,               2'd1, 2, {WordB, 64'h0}, 0);
    txn("ic_line", 0, 0, 0, 64'h100,  3'd0, 64'h0,               2'd2, 3, {WordB, WordP}, 0);
    txn("st_wrap", 1, 1, 0, 64'h8000, 3'd3, WordW,               2'd3, 2, 128'h0, 0);
    txn("ld_wrap", 1, 0, 0, 64'h0,    3'd3, 64'h0,               2'd0, 2, {64'h0, WordW}, 0);
    txn("st_trunc",1, 1, 0, 64'h106,  3'd2, 64'h123456789ABCDEF0, 2'd1, 2, 128'h0, 0);
    txn("ld_trunc",1, 0, 0, 64'h100,  3'd3, 64'h0,               2'd2, 2, {64'h0, WordH}, 0);
    txn("ld_hi",   1, 0, 0, 64'h108,  3'd3, 64'h0,               2'd3, 2, {WordB, 64'h0}, 0);

    // Both requests held continuously: grants must alternate I, D, I, D.
    @(negedge clk_i);
    icache_nc_i       = 1'b0;
    icache_paddr_i    = 64'h100;
    icache_tid_i      = 2'd1;
    dcache_rtype_i    = 1'b0;
    dcache_paddr_i    = 64'h108;
    dcache_size_i     = 3'd3;
    dcache_tid_i      = 2'd2;
    icache_data_req_i = 1'b1;
    dcache_data_req_i = 1'b1;
    n_ack = 0;
    n_ic  = 0;
    n_dc  = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      if (n_ack == 4) begin
        icache_data_req_i = 1'b0;
        dcache_data_req_i = 1'b0;
      end
      #1;
      if (icache_data_ack_o || dcache_data_ack_o) begin
        if (n_ack < 4) begin
          check_eq("arb_port", dcache_data_ack_o, exp_port[n_ack]);
          check_eq("arb_cycle", cyc, exp_cyc[n_ack]);
          check_eq("arb_both", icache_data_ack_o & dcache_data_ack_o, 0);
        end else begin
          check_eq("arb_extra_ack", {icache_data_ack_o, dcache_data_ack_o}, 0);
        end
        n_ack++;
      end
      if (icache_rtrn_vld_o) begin
        n_ic++;
        check_eq("arb_ic_tid", icache_rtrn_tid_o, 2'd1);
        check_eq("arb_ic_data", icache_rtrn_data_o, {WordB, WordH});
      end
      if (dcache_rtrn_vld_o) begin
        n_dc++;
        check_eq("arb_dc_tid", dcache_rtrn_tid_o, 2'd2);
        check_eq("arb_dc_type", dcache_rtrn_type_o, 0);
        check_eq("arb_dc_data", dcache_rtrn_data_o, {WordB, 64'h0});
      end
    end
    check_eq("arb_n_ack", n_ack, 4);
    check_eq("arb_n_ic", n_ic, 2);
    check_eq("arb_n_dc", n_dc, 2);

    // Reset in the middle of an icache line read: no return, pointer back to icache.
    @(negedge clk_i);
    icache_nc_i       = 1'b0;
    icache_paddr_i    = 64'h100;
    icache_tid_i      = 2'd3;
    icache_data_req_i = 1'b1;
    #1;
    check_eq("abort_ack", icache_data_ack_o, 1);
    @(posedge clk_i);
    #1;
    icache_data_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("abort_ic_vld", icache_rtrn_vld_o, 0);
    check_eq("abort_ic_data", icache_rtrn_data_o, 0);
    check_eq("abort_dc_vld", dcache_rtrn_vld_o, 0);
    @(posedge clk_i);
    #1;
    check_eq("abort_edge_ic_vld", icache_rtrn_vld_o, 0);
    check_eq("abort_edge_ic_tid", icache_rtrn_tid_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check_eq("post_rst_ic_vld", icache_rtrn_vld_o, 0);
      check_eq("post_rst_dc_vld", dcache_rtrn_vld_o, 0);
    end
    dcache_rtype_i = 1'b0;
    dcache_paddr_i = 64'h100;
    dcache_size_i  = 3'd3;
    dcache_tid_i   = 2'd0;
    txn("rst_prio", 0, 0, 0, 64'h100, 3'd0, 64'h0, 2'd3, 3, {WordB, WordH}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
